// File: rtl/mm_register_file.sv
`default_nettype none
// ============================================================================
// Module   : mm_register_file
// Purpose  : Memory-mapped register bank behind an address chip select.
//            It latches a selected bus transaction and then inserts
//            WAIT_STATES wait cycles. After that it performs a byte-enabled
//            write or a read and returns a one-cycle acknowledge.
//            All register contents are also exposed as a flat vector.
// Ports    :
//   clk         in   clock, rising edge
//   rst         in   synchronous active-high reset
//   i_cs        in   chip select (address in range, valid, aligned)
//   i_address   in   [ADDR_WIDTH]      byte address
//   i_rnw       in   1 = read, 0 = write
//   i_data_in   in   [DATA_WIDTH]      write data
//   i_byte_en   in   [DATA_WIDTH/8]    per-byte write enable
//   o_data_out  out  [DATA_WIDTH]      read data, valid while o_ack = 1
//   o_ack       out  one-cycle transaction-complete pulse
//   o_regs      out  [NUM_REGS*DATA_WIDTH] reg k at [k*DATA_WIDTH +: DATA_WIDTH]
// Revision : 1.0 - initial release
// ============================================================================
module mm_register_file #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int                    NUM_REGS    = 2,
  parameter int                    WAIT_STATES = 1,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_cs,
  input  logic [ADDR_WIDTH-1:0]          i_address,
  input  logic                           i_rnw,
  input  logic [DATA_WIDTH-1:0]          i_data_in,
  input  logic [DATA_WIDTH/8-1:0]        i_byte_en,
  output logic [DATA_WIDTH-1:0]          o_data_out,
  output logic                           o_ack,
  output logic [NUM_REGS*DATA_WIDTH-1:0] o_regs
);

  localparam int IDX_WIDTH = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int CNT_WIDTH = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
  localparam int BYTES     = DATA_WIDTH / 8;
  localparam logic [CNT_WIDTH-1:0] CNT_LOAD =
    (WAIT_STATES > 0) ? CNT_WIDTH'(WAIT_STATES - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_ACK     = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  state_t                      state;
  state_t                      state_next;
  logic [CNT_WIDTH-1:0]        count;
  logic [IDX_WIDTH-1:0]        cap_idx;
  logic                        cap_rnw;
  logic [DATA_WIDTH-1:0]       cap_data;
  logic [BYTES-1:0]            cap_be;
  logic [ADDR_WIDTH-1:0]       offset;
  logic [IDX_WIDTH-1:0]        bus_idx;
  logic [IDX_WIDTH-1:0]        rd_idx;
  logic                        rd_rnw;
  logic                        capture;
  logic                        enter_ack;
  logic [DATA_WIDTH-1:0]       rd_word;
  logic [DATA_WIDTH-1:0]       data_out;
  logic [NUM_REGS*DATA_WIDTH-1:0] regs;
  logic                        unused_offset_bits;

  // Word index relative to the bank base, truncated to the index width.
  assign offset             = i_address - BASE_ADDR;
  assign bus_idx            = offset[IDX_WIDTH+1:2];
  assign unused_offset_bits = ^{offset[ADDR_WIDTH-1:IDX_WIDTH+2], offset[1:0]};

  assign capture = (state == S_IDLE) && i_cs;

  // With zero wait states, ACK is entered on the capture edge itself. The
  // read lookup must therefore use the live bus index while idle and the
  // latched index otherwise.
  assign rd_idx    = (state == S_IDLE) ? bus_idx : cap_idx;
  assign rd_rnw    = (state == S_IDLE) ? i_rnw   : cap_rnw;
  assign enter_ack = (state_next == S_ACK) && (state != S_ACK);

  // Read mux; an index with no matching register reads as zero.
  always_comb begin
    rd_word = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (rd_idx == IDX_WIDTH'(k)) begin
        rd_word = regs[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (i_cs) begin
          state_next = (WAIT_STATES == 0) ? S_ACK : S_WAIT;
        end
      end
      S_WAIT: begin
        if (count == '0) begin
          state_next = S_ACK;
        end
      end
      S_ACK: begin
        state_next = i_cs ? S_RELEASE : S_IDLE;
      end
      S_RELEASE: begin
        if (!i_cs) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // State, wait counter, transaction capture and read-data register
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      count    <= '0;
      cap_idx  <= '0;
      cap_rnw  <= 1'b1;
      cap_data <= '0;
      cap_be   <= '0;
      data_out <= '0;
    end else begin
      state <= state_next;
      if (capture) begin
        cap_idx  <= bus_idx;
        cap_rnw  <= i_rnw;
        cap_data <= i_data_in;
        cap_be   <= i_byte_en;
        count    <= CNT_LOAD;
      end else if ((state == S_WAIT) && (count != '0)) begin
        count <= count - CNT_WIDTH'(1);
      end
      // Sampled on the edge into ACK. This is the register value as of ACK
      // entry, because writes only land at the end of ACK.
      if (enter_ack && rd_rnw) begin
        data_out <= rd_word;
      end
    end
  end

  // Register storage: byte-enabled write at the end of the ACK cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      regs <= {NUM_REGS{RESET_VALUE}};
    end else if ((state == S_ACK) && !cap_rnw) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        for (int b = 0; b < BYTES; b++) begin
          if ((cap_idx == IDX_WIDTH'(k)) && cap_be[b]) begin
            regs[k*DATA_WIDTH + b*8 +: 8] <= cap_data[b*8 +: 8];
          end
        end
      end
    end
  end

  assign o_ack      = (state == S_ACK);
  assign o_data_out = data_out;
  assign o_regs     = regs;

endmodule
`default_nettype wire

// File: tb/tb_mm_register_file.sv
`default_nettype none
// ============================================================================
// Module   : tb_mm_register_file
// Purpose  : Directed self-checking bench for mm_register_file. Three
//            instances share clk, rst and the bus lines, and each has its own
//            chip select:
//              dut_a : WAIT_STATES=1, NUM_REGS=2
//              dut_b : WAIT_STATES=3, NUM_REGS=2
//              dut_c : WAIT_STATES=0, NUM_REGS=3
// Revision : 1.0 - initial release
// ============================================================================
module tb_mm_register_file;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  cs;
  logic [31:0] addr;
  logic        rnw;
  logic [31:0] din;
  logic [3:0]  be;
  logic [2:0]  ack;
  logic [31:0] dout_a, dout_b, dout_c;
  logic [63:0] regs_a, regs_b;
  logic [95:0] regs_c;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mm_register_file #(.WAIT_STATES(1), .NUM_REGS(2)) dut_a (
    .clk(clk), .rst(rst), .i_cs(cs[0]), .i_address(addr), .i_rnw(rnw),
    .i_data_in(din), .i_byte_en(be), .o_data_out(dout_a), .o_ack(ack[0]),
    .o_regs(regs_a)
  );

  mm_register_file #(.WAIT_STATES(3), .NUM_REGS(2)) dut_b (
    .clk(clk), .rst(rst), .i_cs(cs[1]), .i_address(addr), .i_rnw(rnw),
    .i_data_in(din), .i_byte_en(be), .o_data_out(dout_b), .o_ack(ack[1]),
    .o_regs(regs_b)
  );

  mm_register_file #(.WAIT_STATES(0), .NUM_REGS(3)) dut_c (
    .clk(clk), .rst(rst), .i_cs(cs[2]), .i_address(addr), .i_rnw(rnw),
    .i_data_in(din), .i_byte_en(be), .o_data_out(dout_c), .o_ack(ack[2]),
    .o_regs(regs_c)
  );

  task automatic check(input string tag, input logic [95:0] got,
                       input logic [95:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] dout_of(input int d);
    case (d)
      0:       return dout_a;
      1:       return dout_b;
      default: return dout_c;
    endcase
  endfunction

  // One bus transaction on instance d. Chip select drops and the bus lines
  // are scrambled right after capture; the design must ignore that.
  // Latency is counted in cycles after the capture edge.
  task automatic txn(input string tag, input int d, input int ws,
                     input logic [31:0] a, input logic r,
                     input logic [31:0] data, input logic [3:0] bytes,
                     output logic [31:0] rdata);
    int c;
    @(negedge clk);
    addr = a; rnw = r; din = data; be = bytes; cs[d] = 1'b1;
    c = 0;
    do begin
      @(negedge clk);
      c++;
      cs[d] = 1'b0;
      addr = ~a; rnw = ~r; din = ~data; be = ~bytes;
    end while (!ack[d] && c < 20);
    rdata = dout_of(d);
    check($sformatf("%s latency", tag), 96'(c), 96'(ws + 1));
    @(negedge clk);
    check($sformatf("%s ack pulse", tag), 96'(ack[d]), 96'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    int n;

    // 1. Reset
    rst = 1'b1; cs = 3'b000; addr = '0; rnw = 1'b0; din = '0; be = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset ack", 96'(ack), 96'(0));
    check("reset dout_a", 96'(dout_a), 96'(0));
    check("reset dout_b", 96'(dout_b), 96'(0));
    check("reset dout_c", 96'(dout_c), 96'(0));
    check("reset regs_a", 96'(regs_a), 96'(0));
    check("reset regs_b", 96'(regs_b), 96'(0));
    check("reset regs_c", regs_c, 96'(0));
    rst = 1'b0;

    // 2. Write then read, one wait state
    txn("wr reg1", 0, 1, 32'h4, 1'b0, 32'hDEADBEEF, 4'hF, rd);
    check("reg1 after write", 96'(regs_a), {32'h0, 32'hDEADBEEF, 32'h0});
    txn("rd reg1", 0, 1, 32'h4, 1'b1, 32'h0, 4'h0, rd);
    check("rd reg1 data", 96'(rd), 96'(32'hDEADBEEF));

    // 3. Byte enables; o_data_out is untouched by writes
    txn("wr reg0", 0, 1, 32'h0, 1'b0, 32'h11223344, 4'hF, rd);
    txn("rd reg0", 0, 1, 32'h0, 1'b1, 32'h0, 4'h0, rd);
    check("rd reg0 data", 96'(rd), 96'(32'h11223344));
    txn("wr byte1", 0, 1, 32'h0, 1'b0, 32'h0000AA00, 4'b0010, rd);
    check("byte-enable merge", 96'(regs_a), {32'h0, 32'hDEADBEEF, 32'h1122AA44});
    check("dout held over write", 96'(dout_a), 96'(32'h11223344));

    // 4. Held chip select yields a single transaction
    @(negedge clk);
    addr = 32'h0; rnw = 1'b0; din = 32'h0BADF00D; be = 4'hF; cs[0] = 1'b1;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ack[0]) n++;
      din = 32'hFFFFFFFF;
    end
    check("held cs ack count", 96'(n), 96'(1));
    check("held cs one write", 96'(regs_a[31:0]), 96'(32'h0BADF00D));
    cs[0] = 1'b0;
    @(negedge clk);
    din = 32'h12345678; cs[0] = 1'b1;
    n = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (ack[0]) n++;
    end
    cs[0] = 1'b0;
    check("re-asserted cs ack count", 96'(n), 96'(1));
    check("re-asserted cs write", 96'(regs_a[31:0]), 96'(32'h12345678));

    // 5. Reset in the first wait cycle, three wait states
    txn("b wr reg0", 1, 3, 32'h0, 1'b0, 32'hA5A5A5A5, 4'hF, rd);
    check("b reg0 written", 96'(regs_b), {32'h0, 32'h0, 32'hA5A5A5A5});
    @(negedge clk);
    addr = 32'h4; rnw = 1'b0; din = 32'h55; be = 4'hF; cs[1] = 1'b1;
    @(negedge clk);
    cs[1] = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (ack[1]) n++;
    end
    check("aborted txn no ack", 96'(n), 96'(0));
    check("aborted txn regs_b", 96'(regs_b), 96'(0));
    check("shared reset regs_a", 96'(regs_a), 96'(0));
    txn("b wr after reset", 1, 3, 32'h4, 1'b0, 32'h00000066, 4'hF, rd);
    check("b reg1 after reset", 96'(regs_b), {32'h0, 32'h00000066, 32'h0});

    // 6. Zero wait states, out-of-range index
    txn("c wr reg2", 2, 0, 32'h8, 1'b0, 32'hCAFEF00D, 4'hF, rd);
    check("c reg2 written", regs_c, {32'hCAFEF00D, 32'h0, 32'h0});
    txn("c rd reg2", 2, 0, 32'h8, 1'b1, 32'h0, 4'h0, rd);
    check("c rd reg2 data", 96'(rd), 96'(32'hCAFEF00D));
    txn("c rd oob", 2, 0, 32'hC, 1'b1, 32'h0, 4'h0, rd);
    check("c rd oob data", 96'(rd), 96'(0));
    txn("c wr oob", 2, 0, 32'hC, 1'b0, 32'hFFFFFFFF, 4'hF, rd);
    check("c wr oob no change", regs_c, {32'hCAFEF00D, 32'h0, 32'h0});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mm_register_file.md
Name: mm_register_file

Overview:
- Memory-mapped register bank that sits directly downstream of the address chip select and consumes its o_cs output as i_cs.
- Latches a selected bus transaction, inserts programmable wait states, and performs a byte-enabled write or a read.
- Returns a single-cycle acknowledge to the bus master.
- Exposes all register contents to local hardware as a flat vector.

Parameters:
ADDR_WIDTH, 32, bus address width
DATA_WIDTH, 32, bus data width; multiple of 8
BASE_ADDR, 32'h0, byte address of register 0; must equal the chip select's BASE_ADDR
NUM_REGS, 2, number of DATA_WIDTH registers; word stride 4 bytes
WAIT_STATES, 1, cycles inserted between capture and acknowledge; 0 allowed
RESET_VALUE, 0, reset value of every register (DATA_WIDTH wide)

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
i_cs  input  1  chip select (address in range, valid, aligned)
i_address  input  ADDR_WIDTH  byte address
i_rnw  input  1  1 = read, 0 = write
i_data_in  input  DATA_WIDTH  write data
i_byte_en  input  DATA_WIDTH/8  per-byte write enable
o_data_out  output  DATA_WIDTH  read data, valid while o_ack=1
o_ack  output  1  transaction complete, one-cycle pulse
o_regs  output  NUM_REGS*DATA_WIDTH  register contents; reg k at bits [k*DATA_WIDTH +: DATA_WIDTH]

Behaviour:
- Reset, synchronous, dominates everything:
  - FSM goes to IDLE; o_ack=0; o_data_out=0; every register = RESET_VALUE.
  - An in-flight transaction is discarded: no ack, no write.
- Index: idx = (i_address - BASE_ADDR) >> 2, truncated to max(1, clog2(NUM_REGS)) bits; computed at capture.
- Index ≥ NUM_REGS: write dropped, read returns 0, transaction still acked.
- FSM states: IDLE, WAIT, ACK, RELEASE.
- IDLE:
  - On i_cs=1, latch idx, i_rnw, i_data_in and i_byte_en.
  - Go to WAIT and load counter = WAIT_STATES-1; if WAIT_STATES=0, go directly to ACK.
- WAIT: counter decrements each cycle; go to ACK on the cycle the counter is 0.
- ACK:
  - o_ack=1 for exactly this cycle.
  - Read: o_data_out = reg[idx] as of ACK entry.
  - Write: each byte b with byte_en[b]=1 is updated at the end of the ACK cycle; new value appears on o_regs the next cycle.
  - Next state: IDLE if i_cs=0, else RELEASE.
- RELEASE: wait until i_cs=0, then go to IDLE. A held-high i_cs never produces a second transaction.
- Latency: i_cs sampled high at edge N gives o_ack=1 in cycle N+WAIT_STATES+1.
- Minimum spacing: back-to-back transactions are WAIT_STATES+2 cycles apart (includes one i_cs-low cycle).
- Bus changes after capture (address, data, rnw, byte_en, or i_cs dropping) are ignored until the transaction completes.
- o_data_out holds its last read value outside ACK and is not changed by writes.
- Reads are side-effect free. Only reset and bus writes modify registers.

Test Plan:
1. Reset check: assert rst 2 cycles -> o_ack=0, o_data_out=0, o_regs all RESET_VALUE (0).
2. Write then read, WAIT_STATES=1:
   - Write 0xDEADBEEF to BASE_ADDR+4, byte_en=4'hF, i_cs high at edge 0 -> o_ack=1 in cycle 2 only; o_regs[63:32]=0xDEADBEEF from cycle 3.
   - Read of BASE_ADDR+4 -> o_data_out=0xDEADBEEF with o_ack.
3. Byte enables: reg0=0x11223344; write 0x0000AA00 with byte_en=4'b0010 -> reg0=0x1122AA44.
4. Held chip select: i_cs held high 10 cycles during a write -> exactly one o_ack pulse and one write. Dropping i_cs for one cycle then reasserting -> second ack.
5. Reset mid-operation: WAIT_STATES=3, write 0x55 to reg1, rst asserted in first WAIT cycle -> no o_ack, reg1=RESET_VALUE, FSM idle and accepts a new i_cs next cycle.
6. Zero wait states and out-of-range index: WAIT_STATES=0, NUM_REGS=3, access to BASE_ADDR+12:
   - i_cs at edge 0 -> o_ack in cycle 1.
   - Read returns 0; write leaves all registers unchanged.
